regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32-entry register file; arbitrates between the in-order pipeline writeback (A) and a long-latency execution unit writeback (B, e.g. mul/div).
- Holds a one-entry buffer for B, prevents B starvation by freezing the pipeline, and keeps a busy scoreboard of registers with outstanding B results for hazard detection.
- Sits between writeback stage / long-latency unit and the regfile write port (RegWrite, rd, ResultW).

---
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-port arbitration bundle: pipeline writeback (A), long-latency writeback (B),
// issue/hazard-check signals and the registered regfile write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5
);
    logic                      wbA_valid;
    logic [REG_DATA_WIDTH-1:0] wbA_rd;
    logic [DATA_WIDTH-1:0]     wbA_data;
    logic                      wbB_valid;
    logic                      wbB_ready;
    logic [REG_DATA_WIDTH-1:0] wbB_rd;
    logic [DATA_WIDTH-1:0]     wbB_data;
    logic                      issue_valid;
    logic [REG_DATA_WIDTH-1:0] issue_rd;
    logic [REG_DATA_WIDTH-1:0] chk_rs1;
    logic [REG_DATA_WIDTH-1:0] chk_rs2;
    logic [REG_DATA_WIDTH-1:0] chk_rd;
    logic                      hazard;
    logic                      pipe_stall;
    logic                      RegWrite;
    logic [REG_DATA_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     ResultW;

    modport master (
        output wbA_valid, wbA_rd, wbA_data,
        output wbB_valid, wbB_rd, wbB_data,
        output issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        input  wbB_ready, hazard, pipe_stall, RegWrite, rd, ResultW
    );

    modport slave (
        input  wbA_valid, wbA_rd, wbA_data,
        input  wbB_valid, wbB_rd, wbB_data,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        output wbB_ready, hazard, pipe_stall, RegWrite, rd, ResultW
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter between pipeline writeback (A) and a long-latency unit (B),
// with a one-entry B buffer, anti-starvation stall and busy scoreboard.
// Optional perf counters (conflict_cnt, force_cnt) enabled by defining WB_ARB_PERF_EN.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [15:0]          conflict_cnt,
    output logic [15:0]          force_cnt
`endif
);

    localparam int NREG  = 1 << REG_DATA_WIDTH;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          wait_cnt, wait_nxt;
    logic [REG_DATA_WIDTH-1:0] buf_rd;
    logic [DATA_WIDTH-1:0]     buf_data;
    logic                      buf_load;
    logic                      b_hs;
    logic                      win_vld;
    logic [REG_DATA_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0]     win_data;
    logic                      clr_vld;
    logic [REG_DATA_WIDTH-1:0] clr_rd;
    logic [NREG-1:0]           busy, busy_nxt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign b_hs           = bus.wbB_valid & (state == IDLE);
    assign bus.wbB_ready  = (state == IDLE);
    assign bus.pipe_stall = (state == FORCE);
    assign bus.hazard     = busy[bus.chk_rs1] | busy[bus.chk_rs2] | busy[bus.chk_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        win_vld   = 1'b0;
        win_rd    = '0;
        win_data  = '0;
        clr_vld   = 1'b0;
        clr_rd    = '0;
        buf_load  = 1'b0;
        case (state)
            IDLE: begin
                if (b_hs && !bus.wbA_valid) begin
                    win_vld  = 1'b1;
                    win_rd   = bus.wbB_rd;
                    win_data = bus.wbB_data;
                    clr_vld  = 1'b1;
                    clr_rd   = bus.wbB_rd;
                end else if (b_hs) begin
                    // A keeps the port; B parks in the buffer and starts aging
                    win_vld   = 1'b1;
                    win_rd    = bus.wbA_rd;
                    win_data  = bus.wbA_data;
                    buf_load  = 1'b1;
                    wait_nxt  = CNT_W'(1);
                    state_nxt = (STARVE_LIMIT == 1) ? FORCE : HOLD;
                end else if (bus.wbA_valid) begin
                    win_vld  = 1'b1;
                    win_rd   = bus.wbA_rd;
                    win_data = bus.wbA_data;
                end
            end
            HOLD: begin
                if (!bus.wbA_valid) begin
                    win_vld   = 1'b1;
                    win_rd    = buf_rd;
                    win_data  = buf_data;
                    clr_vld   = 1'b1;
                    clr_rd    = buf_rd;
                    wait_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    win_vld  = 1'b1;
                    win_rd   = bus.wbA_rd;
                    win_data = bus.wbA_data;
                    wait_nxt = wait_cnt + CNT_W'(1);
                    if (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                        state_nxt = FORCE;
                    end
                end
            end
            FORCE: begin
                // Pipeline is frozen, so the held A result is simply not written yet
                win_vld   = 1'b1;
                win_rd    = buf_rd;
                win_data  = buf_data;
                clr_vld   = 1'b1;
                clr_rd    = buf_rd;
                wait_nxt  = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_rd   <= bus.wbB_rd;
            buf_data <= bus.wbB_data;
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the register busy
    always_comb begin
        busy_nxt = busy;
        if (clr_vld) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            busy_nxt[bus.issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RegWrite <= 1'b0;
            bus.rd       <= '0;
            bus.ResultW  <= '0;
        end else begin
            bus.RegWrite <= win_vld && (win_rd != '0);
            if (win_vld) begin
                bus.rd      <= win_rd;
                bus.ResultW <= win_data;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic conflict_ev;
    logic force_ev;

    assign conflict_ev = bus.wbA_valid && (b_hs || (state == HOLD));
    assign force_ev    = (state_nxt == FORCE) && (state != FORCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            force_cnt    <= '0;
        end else begin
            if (conflict_ev) begin
                conflict_cnt <= sat_inc16(conflict_cnt);
            end
            if (force_ev) begin
                force_cnt <= sat_inc16(force_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration and busy tracking.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .REG_DATA_WIDTH(AW)) bus ();

`ifdef WB_ARB_PERF_EN
    logic [15:0] conflict_cnt;
    logic [15:0] force_cnt;
`endif

    regfile_wb_arbiter #(
        .DATA_WIDTH    (DW),
        .REG_DATA_WIDTH(AW),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .conflict_cnt(conflict_cnt),
        .force_cnt   (force_cnt)
`endif
    );

    typedef struct {
        bit              we;
        bit              chk_addr;
        logic [AW-1:0]   rd;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: pending B result and how many A writes it has lost to so far
    bit            pend;
    int            age;
    logic [AW-1:0] p_rd;
    logic [DW-1:0] p_data;
    bit            busy_m[32];
    logic [AW-1:0] out_q[$];
    int            m_conf;
    int            m_force;
    bit            prev_a_v;
    logic [AW-1:0] prev_a_rd;
    logic [DW-1:0] prev_a_d;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void drop_out(logic [AW-1:0] r);
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i] == r) begin
                out_q.delete(i);
                return;
            end
        end
    endfunction

    task automatic step(input bit r, input bit a_v, input logic [AW-1:0] a_rd,
                        input logic [DW-1:0] a_d, input bit b_v, input logic [AW-1:0] b_rd,
                        input logic [DW-1:0] b_d, input bit i_v, input logic [AW-1:0] i_rd,
                        input logic [AW-1:0] c1, input logic [AW-1:0] c2,
                        input logic [AW-1:0] c3);
        bit            stall;
        bit            hs;
        bit            w_v;
        logic [AW-1:0] w_rd;
        logic [DW-1:0] w_d;
        bit            bwr;
        logic [AW-1:0] bw_rd;
        exp_t          e;
        stall = pend && (age >= LIMIT);
        if (stall) begin
            a_v  = prev_a_v;
            a_rd = prev_a_rd;
            a_d  = prev_a_d;
            i_v  = 1'b0;
        end
        @(negedge clk);
        rst             = r;
        bus.wbA_valid   = a_v;
        bus.wbA_rd      = a_rd;
        bus.wbA_data    = a_d;
        bus.wbB_valid   = b_v;
        bus.wbB_rd      = b_rd;
        bus.wbB_data    = b_d;
        bus.issue_valid = i_v;
        bus.issue_rd    = i_rd;
        bus.chk_rs1     = c1;
        bus.chk_rs2     = c2;
        bus.chk_rd      = c3;
        #1;
        check("wbB_ready", 32'(bus.wbB_ready), 32'(!pend));
        check("pipe_stall", 32'(bus.pipe_stall), 32'(stall));
        check("hazard", 32'(bus.hazard), 32'(busy_m[c1] | busy_m[c2] | busy_m[c3]));
        prev_a_v  = a_v;
        prev_a_rd = a_rd;
        prev_a_d  = a_d;
        if (r) begin
            e = '{we: 1'b0, chk_addr: 1'b1, rd: '0, data: '0};
            pend = 1'b0;
            age  = 0;
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            out_q.delete();
            m_conf  = 0;
            m_force = 0;
        end else begin
            hs   = b_v && !pend;
            w_v  = 1'b0;
            w_rd = '0;
            w_d  = '0;
            bwr  = 1'b0;
            bw_rd = '0;
            if (pend) begin
                if (stall || !a_v) begin
                    w_v = 1'b1; w_rd = p_rd; w_d = p_data;
                    bwr = 1'b1; bw_rd = p_rd;
                    pend = 1'b0; age = 0;
                end else begin
                    w_v = 1'b1; w_rd = a_rd; w_d = a_d;
                    age++;
                    m_conf++;
                    if (age == LIMIT) m_force++;
                end
            end else if (hs && a_v) begin
                w_v = 1'b1; w_rd = a_rd; w_d = a_d;
                pend = 1'b1; age = 1; p_rd = b_rd; p_data = b_d;
                m_conf++;
                if (LIMIT == 1) m_force++;
                drop_out(b_rd);
            end else if (hs) begin
                w_v = 1'b1; w_rd = b_rd; w_d = b_d;
                bwr = 1'b1; bw_rd = b_rd;
                drop_out(b_rd);
            end else if (a_v) begin
                w_v = 1'b1; w_rd = a_rd; w_d = a_d;
            end
            e.we       = w_v && (w_rd != '0);
            e.chk_addr = e.we;
            e.rd       = w_rd;
            e.data     = w_d;
            if (bwr) busy_m[bw_rd] = 1'b0;
            if (i_v && (i_rd != '0)) begin
                busy_m[i_rd] = 1'b1;
                out_q.push_back(i_rd);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [AW-1:0] c1);
        step(0, 0, '0, '0, 0, '0, '0, 0, '0, c1, '0, '0);
    endtask

    task automatic issue(input logic [AW-1:0] r);
        step(0, 0, '0, '0, 0, '0, '0, 1, r, '0, '0, '0);
    endtask

    // Monitor: one expected output per clock edge, popped just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("RegWrite", 32'(bus.RegWrite), 32'(e.we));
            if (e.chk_addr) begin
                check("rd", 32'(bus.rd), 32'(e.rd));
                check("ResultW", bus.ResultW, e.data);
            end
        end
    end

    initial begin
        bit            a_v, b_v, i_v, r;
        logic [AW-1:0] a_rd, b_rd, i_rd, c1, c2, c3;
        logic [DW-1:0] a_d, b_d;

        pend = 0; age = 0; m_conf = 0; m_force = 0;
        prev_a_v = 0; prev_a_rd = '0; prev_a_d = '0;
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        rst = 1'b1;
        bus.wbA_valid = 0; bus.wbA_rd = '0; bus.wbA_data = '0;
        bus.wbB_valid = 0; bus.wbB_rd = '0; bus.wbB_data = '0;
        bus.issue_valid = 0; bus.issue_rd = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;

        step(1, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0, '0);
        step(1, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0, '0);
        idle('0);

        // B bypass with hazard release
        issue(5'd7);
        step(0, 0, '0, '0, 1, 5'd7, 32'hDEADBEEF, 0, '0, 5'd7, '0, '0);
        idle(5'd7);

        // Collision: A first, buffered B next cycle
        issue(5'd9);
        step(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'h22, 0, '0, 5'd9, '0, '0);
        idle(5'd9);
        idle(5'd9);
`ifdef WB_ARB_PERF_EN
        @(negedge clk);
        check("conflict_cnt_collision", 32'(conflict_cnt), 32'd1);
`endif

        // Starvation: A every cycle until the forced B write
        issue(5'd10);
        step(0, 1, 5'd1, 32'hA1, 1, 5'd10, 32'hB10, 0, '0, 5'd10, '0, '0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, AW'(k + 2), DW'(32'hA0 + k), 0, '0, '0, 0, '0, 5'd10, '0, '0);
        end
        idle('0);

        // x0 handling
        step(0, 1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, 0, '0, '0, '0, '0);
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd0, 5'd0, 5'd0, 5'd0);
        idle('0);

        // Same-cycle set and clear of r4
        issue(5'd4);
        step(0, 0, '0, '0, 1, 5'd4, 32'h44, 1, 5'd4, 5'd4, '0, '0);
        idle(5'd4);
        check("busy4_after_setclear", 32'(bus.hazard), 32'd1);
        step(0, 0, '0, '0, 1, 5'd4, 32'h45, 0, '0, 5'd4, '0, '0);
        idle(5'd4);

        // Reset while B sits in the buffer
        issue(5'd5);
        step(0, 1, 5'd2, 32'h22, 1, 5'd5, 32'h55, 0, '0, 5'd5, '0, '0);
        step(1, 1, 5'd2, 32'h23, 0, '0, '0, 0, '0, 5'd5, '0, '0);
        idle(5'd5);
        check("ready_after_reset", 32'(bus.wbB_ready), 32'd1);
        check("hazard_after_reset", 32'(bus.hazard), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            a_v = ($urandom_range(0, 3) != 0);
            a_rd = AW'($urandom);
            for (int t = 0; t < 8 && busy_m[a_rd]; t++) a_rd = AW'($urandom);
            if (busy_m[a_rd]) a_rd = '0;
            a_d = $urandom;
            b_v = 1'b0;
            b_rd = AW'($urandom);
            b_d = $urandom;
            if (out_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                b_v  = 1'b1;
                b_rd = out_q[$urandom_range(0, out_q.size() - 1)];
            end
            i_rd = AW'($urandom);
            i_v  = ($urandom_range(0, 2) == 0) && !busy_m[i_rd];
            c1 = AW'($urandom);
            c2 = AW'($urandom);
            c3 = (out_q.size() != 0) ? out_q[0] : AW'($urandom);
            step(r, a_v, a_rd, a_d, b_v, b_rd, b_d, i_v, i_rd, c1, c2, c3);
        end
        for (int k = 0; k < 8; k++) idle('0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef WB_ARB_PERF_EN
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        check("force_cnt", 32'(force_cnt), 32'(m_force));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
